// File: rtl/corelet_pkg.sv
// Shared constants for the corelet instruction sequencer: geometry,
// inst_q bit positions, the idle instruction word and the FSM states.
package corelet_pkg;

    localparam int ROW      = 8;   // MAC array rows (L0 width in vectors)
    localparam int COL      = 8;   // MAC array columns (weight vectors per tile)
    localparam int ADDR_W   = 11;  // SRAM address width
    localparam int L0_DEPTH = 64;  // L0 depth, upper bound on activations per tile
    localparam int SETTLE   = 16;  // idle cycles after the weight load (ROW + COL)
    localparam int INST_W   = 34;

    // inst_q bit map
    localparam int ACC       = 33;
    localparam int PMEM_CEN  = 32;
    localparam int PMEM_WEN  = 31;
    localparam int PMEM_ADDR = 20;  // [30:20]
    localparam int XMEM_CEN  = 19;
    localparam int XMEM_WEN  = 18;
    localparam int XMEM_ADDR = 7;   // [17:7]
    localparam int OFIFO_RD  = 6;
    localparam int IFIFO     = 4;   // [5:4]
    localparam int L0_RD     = 3;
    localparam int L0_WR     = 2;
    localparam int EXECUTE   = 1;
    localparam int LOAD      = 0;

    // Both SRAMs deselected and write-disabled, every strobe low.
    localparam logic [INST_W-1:0] INST_IDLE = 34'h1_800C_0000;

    typedef enum logic [2:0] {
        S_IDLE     = 3'd0,
        S_W_FILL   = 3'd1,
        S_W_LOAD   = 3'd2,
        S_W_SETTLE = 3'd3,
        S_A_FILL   = 3'd4,
        S_EXEC     = 3'd5,
        S_DRAIN    = 3'd6,
        S_DONE     = 3'd7
    } state_t;

endpackage

// File: rtl/corelet_ctrl_cnt.sv
// Loadable down-counter with a zero flag. Load wins over decrement and the
// count holds at zero, so a phase of length L is timed by loading L-1 and
// leaving when zero_o is seen.
module corelet_ctrl_cnt
    import corelet_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load_i,
    input  logic [ADDR_W-1:0] load_val_i,
    input  logic              dec_i,
    output logic              zero_o
);

    logic [ADDR_W-1:0] cnt_q, cnt_d;

    // Next count: load has priority, decrement saturates at zero.
    always_comb begin
        cnt_d = cnt_q;
        if (load_i) begin
            cnt_d = load_val_i;
        end else if (dec_i && (cnt_q != '0)) begin
            cnt_d = cnt_q - 1'b1;
        end
    end

    // Count register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) cnt_q <= '0;
        else       cnt_q <= cnt_d;
    end

    assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/corelet_ctrl.sv
// Corelet instruction sequencer. One accepted start runs a full tile:
// weights xmem->L0->array, settle, activations xmem->L0->execute, then the
// output FIFO is drained into pmem. inst_q is fully registered, so every
// field appears the cycle after the state that produced it.
//
// Drain handshake: ofifo_rd is raised (in inst_q) the cycle after
// ofifo_valid is sampled high while reads remain; the pmem write for that
// row follows in the next inst_q cycle at p_base + k.
module corelet_ctrl
    import corelet_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              start,
    input  logic [ADDR_W-1:0] n_act,
    input  logic [ADDR_W-1:0] w_base,
    input  logic [ADDR_W-1:0] a_base,
    input  logic [ADDR_W-1:0] p_base,
    input  logic              l0_full,
    input  logic              ofifo_valid,
    output logic [INST_W-1:0] inst_q,
    output logic              busy,
    output logic              done,
    output logic              err,
    output state_t            dbg_state
);

    state_t            state_q, state_d;
    logic [ADDR_W-1:0] cnt_q, cnt_d;      // cycle index in phase / reads issued in DRAIN
    logic [ADDR_W-1:0] k_q, k_d;          // pmem write offset
    logic [ADDR_W-1:0] n_act_q, w_base_q, a_base_q, p_base_q;
    logic [INST_W-1:0] inst_d;
    logic              busy_q, busy_d, done_q, done_d, err_q, err_d;
    logic              accept, reject;
    logic              ph_load, ph_zero;
    logic [ADDR_W-1:0] ph_val;
    logic              dr_load, dr_dec, dr_zero;
    logic [ADDR_W-1:0] dr_val;

    // Phase length timer: reloaded on every phase transition.
    corelet_ctrl_cnt u_phase_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (ph_load),
        .load_val_i (ph_val),
        .dec_i      (1'b1),
        .zero_o     (ph_zero)
    );

    // Remaining pmem writes during DRAIN.
    corelet_ctrl_cnt u_drain_cnt (
        .clk        (clk),
        .reset      (reset),
        .load_i     (dr_load),
        .load_val_i (dr_val),
        .dec_i      (dr_dec),
        .zero_o     (dr_zero)
    );

    // Next state, phase counters and the next instruction word.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q + 1'b1;
        k_d     = k_q;
        inst_d  = INST_IDLE;
        ph_load = 1'b0;
        ph_val  = '0;
        dr_load = 1'b0;
        dr_val  = '0;
        dr_dec  = 1'b0;
        accept  = 1'b0;
        reject  = 1'b0;

        case (state_q)
            S_IDLE: begin
                cnt_d = '0;
                if (start) begin
                    if ((n_act == '0) || (n_act > ADDR_W'(L0_DEPTH))) begin
                        reject = 1'b1;
                    end else begin
                        accept  = 1'b1;
                        state_d = S_W_FILL;
                        ph_load = 1'b1;
                        ph_val  = ADDR_W'(COL);      // COL reads + 1 trailing l0_wr
                        k_d     = '0;
                    end
                end
            end
            S_W_FILL: begin
                if (cnt_q < ADDR_W'(COL)) begin
                    inst_d[XMEM_CEN]                 = 1'b0;
                    inst_d[XMEM_ADDR +: ADDR_W]      = w_base_q + cnt_q;
                end
                // SRAM data arrives one cycle after its read.
                if (cnt_q != '0) inst_d[L0_WR] = 1'b1;
                if (ph_zero) begin
                    state_d = S_W_LOAD;
                    cnt_d   = '0;
                    ph_load = 1'b1;
                    ph_val  = ADDR_W'(COL - 1);
                end
            end
            S_W_LOAD: begin
                inst_d[L0_RD] = 1'b1;
                inst_d[LOAD]  = 1'b1;
                if (ph_zero) begin
                    state_d = S_W_SETTLE;
                    cnt_d   = '0;
                    ph_load = 1'b1;
                    ph_val  = ADDR_W'(SETTLE - 1);
                end
            end
            S_W_SETTLE: begin
                if (ph_zero) begin
                    state_d = S_A_FILL;
                    cnt_d   = '0;
                    ph_load = 1'b1;
                    ph_val  = n_act_q;               // n_act reads + 1 trailing l0_wr
                end
            end
            S_A_FILL: begin
                if (cnt_q < n_act_q) begin
                    inst_d[XMEM_CEN]            = 1'b0;
                    inst_d[XMEM_ADDR +: ADDR_W] = a_base_q + cnt_q;
                end
                if (cnt_q != '0) inst_d[L0_WR] = 1'b1;
                if (ph_zero) begin
                    state_d = S_EXEC;
                    cnt_d   = '0;
                    ph_load = 1'b1;
                    ph_val  = n_act_q - 1'b1;
                end
            end
            S_EXEC: begin
                inst_d[L0_RD]   = 1'b1;
                inst_d[EXECUTE] = 1'b1;
                if (ph_zero) begin
                    state_d = S_DRAIN;
                    cnt_d   = '0;
                    dr_load = 1'b1;
                    dr_val  = n_act_q - 1'b1;
                end
            end
            S_DRAIN: begin
                cnt_d = cnt_q;
                if (ofifo_valid && (cnt_q < n_act_q)) begin
                    inst_d[OFIFO_RD] = 1'b1;
                    cnt_d            = cnt_q + 1'b1;
                end
                // Write the row read out in the previous inst_q cycle.
                if (inst_q[OFIFO_RD]) begin
                    inst_d[PMEM_CEN]            = 1'b0;
                    inst_d[PMEM_WEN]            = 1'b0;
                    inst_d[PMEM_ADDR +: ADDR_W] = p_base_q + k_q;
                    k_d                         = k_q + 1'b1;
                    dr_dec                      = 1'b1;
                    if (dr_zero) begin
                        state_d = S_DONE;
                        cnt_d   = '0;
                    end
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
            default: begin
                state_d = S_IDLE;
                cnt_d   = '0;
            end
        endcase
    end

    // Status flags: busy spans start+1 through the done cycle, err is sticky.
    always_comb begin
        busy_d = (state_q != S_IDLE) || accept;
        done_d = (state_q == S_DONE);
        err_d  = err_q;
        if (accept)                    err_d = 1'b0;
        if (reject)                    err_d = 1'b1;
        if (inst_q[L0_WR] && l0_full)  err_d = 1'b1;
    end

    // State, counters, latched tile parameters and registered outputs.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            k_q      <= '0;
            n_act_q  <= '0;
            w_base_q <= '0;
            a_base_q <= '0;
            p_base_q <= '0;
            inst_q   <= INST_IDLE;
            busy_q   <= 1'b0;
            done_q   <= 1'b0;
            err_q    <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            k_q     <= k_d;
            inst_q  <= inst_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
            err_q   <= err_d;
            if (accept) begin
                n_act_q  <= n_act;
                w_base_q <= w_base;
                a_base_q <= a_base;
                p_base_q <= p_base;
            end
        end
    end

    assign busy      = busy_q;
    assign done      = done_q;
    assign err       = err_q;
    assign dbg_state = state_q;

endmodule

// File: tb/tb_corelet_ctrl.sv
// Directed bench for corelet_ctrl: each tile's inst_q trace is captured
// cycle by cycle and compared against a hand-built expected word list.
module tb_corelet_ctrl;
    import corelet_pkg::*;

    // ---------------- clock / reset / DUT ----------------
    logic        clk = 1'b0;
    logic        reset;
    logic        start;
    logic [10:0] n_act, w_base, a_base, p_base;
    logic        l0_full, ofifo_valid;
    logic [33:0] inst_q;
    logic        busy, done, err;
    state_t      dbg_state;

    always #5 clk = ~clk;

    corelet_ctrl dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .n_act       (n_act),
        .w_base      (w_base),
        .a_base      (a_base),
        .p_base      (p_base),
        .l0_full     (l0_full),
        .ofifo_valid (ofifo_valid),
        .inst_q      (inst_q),
        .busy        (busy),
        .done        (done),
        .err         (err),
        .dbg_state   (dbg_state)
    );

    // ---------------- scoreboard ----------------
    localparam logic [33:0] IDLE_W = 34'h1_800C_0000;
    localparam logic [33:0] B_LD   = 34'h1;
    localparam logic [33:0] B_EXE  = 34'h2;
    localparam logic [33:0] B_L0WR = 34'h4;
    localparam logic [33:0] B_L0RD = 34'h8;
    localparam logic [33:0] B_RD   = 34'h40;

    int          checks = 0;
    int          errors = 0;
    logic [33:0] exp_q[$];
    logic [33:0] tr_inst[$];
    logic        tr_busy[$];
    logic        tr_done[$];
    logic        tr_err[$];

    task automatic chk(input string tag, input logic [33:0] obs, input logic [33:0] expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, expv);
        end
    endtask

    task automatic chk_int(input string tag, input int obs, input int expv);
        checks++;
        assert (obs === expv) else begin
            errors++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, expv);
        end
    endtask

    function automatic logic [33:0] xrd(input logic [10:0] a);
        logic [33:0] w;
        w = IDLE_W;
        w[19] = 1'b0;
        w[17:7] = a;
        return w;
    endfunction

    function automatic logic [33:0] pwr(input logic [10:0] a);
        logic [33:0] w;
        w = IDLE_W;
        w[32] = 1'b0;
        w[31] = 1'b0;
        w[30:20] = a;
        return w;
    endfunction

    // Expected words for trace index 0 (start edge) through the last execute.
    task automatic build_phases(input int n, input logic [10:0] wb, input logic [10:0] ab);
        exp_q = {};
        exp_q.push_back(IDLE_W);
        for (int i = 0; i < 8; i++)
            exp_q.push_back(xrd(wb + 11'(i)) | ((i > 0) ? B_L0WR : 34'h0));
        exp_q.push_back(IDLE_W | B_L0WR);
        for (int i = 0; i < 8; i++)  exp_q.push_back(IDLE_W | B_L0RD | B_LD);
        for (int i = 0; i < 16; i++) exp_q.push_back(IDLE_W);
        for (int i = 0; i < n; i++)
            exp_q.push_back(xrd(ab + 11'(i)) | ((i > 0) ? B_L0WR : 34'h0));
        exp_q.push_back(IDLE_W | B_L0WR);
        for (int i = 0; i < n; i++)  exp_q.push_back(IDLE_W | B_L0RD | B_EXE);
    endtask

    // Drain with ofifo_valid always high: back-to-back reads, writes one behind.
    task automatic push_drain_streaming(input int n, input logic [10:0] pb);
        exp_q.push_back(IDLE_W | B_RD);
        for (int i = 0; i < n - 1; i++) exp_q.push_back(pwr(pb + 11'(i)) | B_RD);
        exp_q.push_back(pwr(pb + 11'(n - 1)));
        exp_q.push_back(IDLE_W);   // done cycle
    endtask

    // ---------------- driver ----------------
    task automatic run_tile(input int n, input logic [10:0] wb, input logic [10:0] ab,
                            input logic [10:0] pb, input int stall_from,
                            input int full_lo, input int full_hi);
        int done_k;
        @(negedge clk);
        n_act  = 11'(n);
        w_base = wb;
        a_base = ab;
        p_base = pb;
        start  = 1'b1;
        tr_inst = {}; tr_busy = {}; tr_done = {}; tr_err = {};
        done_k = -1;
        for (int k = 0; k < 400; k++) begin
            @(negedge clk);
            tr_inst.push_back(inst_q);
            tr_busy.push_back(busy);
            tr_done.push_back(done);
            tr_err.push_back(err);
            start = 1'b0;
            ofifo_valid = (stall_from < 0) ? 1'b1
                        : ((k >= stall_from) && (((k - stall_from) % 2) == 0));
            l0_full = (k >= full_lo) && (k <= full_hi);
            if ((done === 1'b1) && (done_k < 0)) done_k = k;
            if ((done_k >= 0) && (k >= done_k + 2)) break;
        end
        ofifo_valid = 1'b0;
        l0_full     = 1'b0;
        chk_int("done_seen", int'(done_k >= 0), 1);
    endtask

    task automatic check_tile(input string tag);
        int ndone, dk, nbusy;
        for (int k = 0; k < exp_q.size(); k++)
            chk($sformatf("%s_inst[%0d]", tag, k),
                (k < tr_inst.size()) ? tr_inst[k] : 34'bx, exp_q[k]);
        ndone = 0; dk = -1; nbusy = 0;
        for (int k = 0; k < tr_done.size(); k++) begin
            if (tr_done[k] === 1'b1) begin ndone++; dk = k; end
            if (tr_busy[k] === 1'b1) nbusy++;
        end
        chk_int({tag, "_done_count"}, ndone, 1);
        chk_int({tag, "_done_idx"}, dk, exp_q.size() - 1);
        chk_int({tag, "_busy_cycles"}, nbusy, exp_q.size());
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int nw;
        reset = 1'b1; start = 1'b0; n_act = '0; w_base = '0; a_base = '0; p_base = '0;
        l0_full = 1'b0; ofifo_valid = 1'b0;
        repeat (3) @(negedge clk);
        chk("reset_inst", inst_q, IDLE_W);
        chk_int("reset_busy", int'(busy), 0);
        chk_int("reset_done", int'(done), 0);
        chk_int("reset_err", int'(err), 0);
        chk_int("reset_state", int'(dbg_state), 0);
        reset = 1'b0;
        @(negedge clk);
        chk("idle_inst", inst_q, IDLE_W);

        // Basic tile: n_act=4, weights at 0, activations at 100, psums at 0.
        run_tile(4, 11'd0, 11'd100, 11'd0, -1, -1, -2);
        build_phases(4, 11'd0, 11'd100);
        push_drain_streaming(4, 11'd0);
        check_tile("basic");
        chk_int("basic_err", int'(err), 0);

        // Drain stall: valid low 10 DRAIN cycles, then 1/0 toggling.
        run_tile(3, 11'd0, 11'd200, 11'd10, 50, -1, -2);
        build_phases(3, 11'd0, 11'd200);
        for (int i = 0; i < 10; i++) exp_q.push_back(IDLE_W);
        exp_q.push_back(IDLE_W | B_RD);
        exp_q.push_back(pwr(11'd10));
        exp_q.push_back(IDLE_W | B_RD);
        exp_q.push_back(pwr(11'd11));
        exp_q.push_back(IDLE_W | B_RD);
        exp_q.push_back(pwr(11'd12));
        exp_q.push_back(IDLE_W);
        check_tile("stall");

        // Rejected starts: n_act=0 and n_act=65.
        @(negedge clk);
        n_act = 11'd0; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_int("rej0_err", int'(err), 1);
        chk_int("rej0_busy", int'(busy), 0);
        chk("rej0_inst", inst_q, IDLE_W);
        n_act = 11'd65; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk_int("rej65_busy", int'(busy), 0);
        chk_int("rej65_state", int'(dbg_state), 0);
        chk_int("rej65_err", int'(err), 1);
        @(negedge clk);
        chk("rej65_inst", inst_q, IDLE_W);

        // Valid start clears err; l0_full during A_FILL writes sets it again.
        run_tile(2, 11'd5, 11'd2045, 11'd7, -1, 35, 36);
        build_phases(2, 11'd5, 11'd2045);
        push_drain_streaming(2, 11'd7);
        check_tile("ovf");
        chk_int("ovf_err_cleared", int'(tr_err[0]), 0);
        chk_int("ovf_err_before", int'(tr_err[35]), 0);
        chk_int("ovf_err_set", int'(tr_err[36]), 1);
        chk_int("ovf_err_sticky", int'(err), 1);

        // pmem address wrap: 2046, 2047, 0, 1.
        run_tile(4, 11'd16, 11'd32, 11'd2046, -1, -1, -2);
        build_phases(4, 11'd16, 11'd32);
        push_drain_streaming(4, 11'd2046);
        check_tile("wrap");
        chk_int("wrap_err_cleared", int'(err), 0);

        // Largest legal tile.
        run_tile(64, 11'd0, 11'd512, 11'd100, -1, -1, -2);
        build_phases(64, 11'd0, 11'd512);
        push_drain_streaming(64, 11'd100);
        check_tile("max");

        // Reset during EXEC (inst_q index 40 is an execute cycle).
        @(negedge clk);
        n_act = 11'd4; w_base = 11'd0; a_base = 11'd100; p_base = 11'd0; start = 1'b1;
        for (int k = 0; k <= 40; k++) begin
            @(negedge clk);
            start = 1'b0;
            ofifo_valid = 1'b1;
        end
        chk("pre_reset_exec", inst_q, IDLE_W | B_L0RD | B_EXE);
        reset = 1'b1;
        #1;
        chk("rst_inst", inst_q, IDLE_W);
        chk_int("rst_busy", int'(busy), 0);
        chk_int("rst_state", int'(dbg_state), 0);
        @(negedge clk);
        reset = 1'b0;
        nw = 0;
        for (int k = 0; k < 12; k++) begin
            @(negedge clk);
            if ((inst_q[32] !== 1'b1) || (inst_q[6] !== 1'b0)) nw++;
        end
        chk_int("rst_no_pmem_write", nw, 0);
        chk_int("rst_busy_after", int'(busy), 0);
        ofifo_valid = 1'b0;

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
